// File: rtl/ifu_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl_pkg
// Shared definitions for the fetch sequencer: default widths and sizes, the
// reset PC, FSM state encodings and the instruction-buffer entry layout.
// ---------------------------------------------------------------------------
package ifu_fetch_ctrl_pkg;

  localparam int          DEF_XLEN      = 32;  // address width
  localparam int          DEF_ILEN      = 32;  // instruction width
  localparam int          DEF_BUF_DEPTH = 8;
  localparam int          DEF_MAX_OUTST = 4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Instruction buffer entry: {inst[63:32], addr[31:0]}
  typedef struct packed {
    logic [DEF_ILEN-1:0] inst;
    logic [DEF_XLEN-1:0] addr;
  } buf_entry_t;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl_if
// Instruction-bus read channel between the fetch sequencer and the bus.
//   req_vld/req_rdy/req_addr : read request handshake (master drives vld/addr)
//   rsp_vld/rsp_data         : in-order read response (slave drives)
// Modports: master = fetch sequencer side, slave = bus side.
// ---------------------------------------------------------------------------
interface ifu_fetch_ctrl_if
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);
  logic            req_vld;
  logic            req_rdy;
  logic [XLEN-1:0] req_addr;
  logic            rsp_vld;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_vld,
    output req_addr,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_data
  );

  modport slave (
    input  req_vld,
    input  req_addr,
    output req_rdy,
    output rsp_vld,
    output rsp_data
  );
endinterface

// File: rtl/ifu_addr_queue.sv
// ---------------------------------------------------------------------------
// ifu_addr_queue
// Small register FIFO holding the addresses of outstanding bus reads so each
// in-order response can be tagged with its address.
// Ports:
//   i_clk, i_rstn     : clock, async active-low reset
//   i_push/i_push_data: enqueue an address
//   i_pop             : dequeue the head
//   i_clear           : drop all entries (has priority over push/pop)
//   o_head            : oldest address
//   o_empty/o_full    : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifu_addr_queue
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTST,
  parameter int WIDTH = DEF_XLEN
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !i_clear;
  assign w_pop  = i_pop && !i_clear;

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl
// Fetch sequencer in front of the IFU->BPU instruction buffer. Owns the fetch
// PC, issues in-order credit-limited bus reads, tags each response with its
// address and writes {inst, addr} into the buffer. A redirect flushes the
// buffer, reloads the PC and discards every stale in-flight response.
// Ports:
//   i_clk, i_rstn            : clock, async active-low reset
//   i_redirect/i_redirect_pc : flush pulse and new fetch PC
//   i_halt                   : stop issuing new requests
//   bus (master)             : instruction-bus request/response channel
//   i_buf_cnt                : downstream buffer occupancy
//   o_buf_wen/o_buf_data     : buffer write, {inst, addr}
//   o_buf_flush              : buffer flush (same cycle as redirect)
// ---------------------------------------------------------------------------
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int              MAX_OUTST = DEF_MAX_OUTST,
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirect_pc,
  input  logic                       i_halt,
  ifu_fetch_ctrl_if.master           bus,
  input  logic [$clog2(BUF_DEPTH):0] i_buf_cnt,
  output logic                       o_buf_wen,
  output logic [2*XLEN-1:0]          o_buf_data,
  output logic                       o_buf_flush
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTST) + 1;
  localparam int SUM_W = CNT_W + 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [OUT_W-1:0] r_outst;
  logic [OUT_W-1:0] r_discard;

  logic [SUM_W-1:0] w_credit_sum;
  logic             w_credit_ok;
  logic             w_req_vld;
  logic             w_accept;
  logic             w_rsp;
  logic             w_rsp_drop;
  logic             w_rsp_write;
  logic [OUT_W-1:0] w_outst_rsp;
  logic [OUT_W-1:0] w_outst_next;
  logic [OUT_W-1:0] w_discard_next;
  logic [XLEN-1:0]  w_q_head;
  logic             w_q_empty;
  logic             w_q_full;

  // Every outstanding read will land in the buffer, so count it as used.
  assign w_credit_sum = SUM_W'(i_buf_cnt) + SUM_W'(r_outst);
  assign w_credit_ok  = (w_credit_sum < SUM_W'(BUF_DEPTH)) &&
                        (r_outst < OUT_W'(MAX_OUTST));

  assign w_req_vld = (r_state == ST_FETCH) && w_credit_ok && !i_halt && !i_redirect;
  assign w_accept  = w_req_vld && bus.req_rdy;

  // A response arriving in the redirect cycle is already stale.
  assign w_rsp       = bus.rsp_vld;
  assign w_rsp_drop  = w_rsp && ((r_discard != '0) || i_redirect);
  assign w_rsp_write = w_rsp && !w_rsp_drop;

  assign w_outst_rsp    = r_outst - OUT_W'(w_rsp);
  assign w_outst_next   = w_outst_rsp + OUT_W'(w_accept);
  assign w_discard_next = (w_rsp && (r_discard != '0)) ? (r_discard - OUT_W'(1)) : r_discard;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_RST;
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (i_redirect) begin
      r_pc      <= {i_redirect_pc[XLEN-1:2], 2'b00};
      r_outst   <= w_outst_rsp;
      r_discard <= w_outst_rsp;
      r_state   <= (w_outst_rsp != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (w_accept) begin
        r_pc <= r_pc + XLEN'(4);
      end
      r_outst   <= w_outst_next;
      r_discard <= w_discard_next;
      case (r_state)
        ST_RST:   r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_FETCH;
        ST_DRAIN: r_state <= (w_discard_next == '0) ? ST_FETCH : ST_DRAIN;
        default:  r_state <= ST_RST;
      endcase
    end
  end

  ifu_addr_queue #(
    .DEPTH (MAX_OUTST),
    .WIDTH (XLEN)
  ) u_addr_queue (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (w_accept),
    .i_push_data (r_pc),
    .i_pop       (w_rsp_write),
    .i_clear     (i_redirect),
    .o_head      (w_q_head),
    .o_empty     (w_q_empty),
    .o_full      (w_q_full)
  );

  // Outputs are forced low while reset is asserted.
  assign bus.req_vld  = w_req_vld;
  assign bus.req_addr = i_rstn ? r_pc : '0;
  assign o_buf_wen    = w_rsp_write && i_rstn;
  assign o_buf_data   = o_buf_wen ? {bus.rsp_data, w_q_head} : '0;
  assign o_buf_flush  = i_redirect && i_rstn;

  a_rsp_has_outst: assert property (@(posedge i_clk) disable iff (!i_rstn)
    bus.rsp_vld |-> (r_outst != '0));
  a_buf_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_buf_wen |-> (i_buf_cnt < CNT_W'(BUF_DEPTH)));
  a_queue_has_addr: assert property (@(posedge i_clk) disable iff (!i_rstn)
    o_buf_wen |-> !w_q_empty);
  a_queue_has_room: assert property (@(posedge i_clk) disable iff (!i_rstn)
    w_accept |-> !w_q_full);

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Fetch sequencer in front of the IFU-to-BPU instruction buffer (the 8-entry, 64-bit sync FIFO that carries {inst, addr}). It owns the fetch PC and issues in-order instruction-bus read requests. Issue is credit-limited so the buffer never overflows, and the block tags each response with its address before writing it into the buffer. On a redirect it flushes the buffer, reloads the PC and silently discards every stale in-flight response.

Parameters:
XLEN, 32, address/instruction width
BUF_DEPTH, 8, entries in the downstream instruction buffer
MAX_OUTST, 4, max outstanding bus reads (power of two, ≤ BUF_DEPTH)
RESET_PC, 32'h8000_0000, PC after reset

Ports:
i_clk  in  1  clock
i_rstn  in  1  async active-low reset
i_redirect  in  1  flush/redirect pulse (branch mispredict, trap, fence.i)
i_redirect_pc  in  XLEN  new fetch PC, valid with i_redirect
i_halt  in  1  stop issuing new requests (WFI/debug); in-flight requests complete
o_req_vld  out  1  bus read request valid
i_req_rdy  in  1  bus accepts request
o_req_addr  out  XLEN  request address (word aligned)
i_rsp_vld  in  1  bus read data valid (responses return in order)
i_rsp_data  in  XLEN  instruction word
i_buf_cnt  in  $clog2(BUF_DEPTH)+1  buffer occupancy
o_buf_wen  out  1  write to buffer
o_buf_data  out  XLEN+XLEN  {inst, addr}
o_buf_flush  out  1  buffer flush

Behaviour:
- Reset: the async assert of i_rstn forces state=RST, pc=RESET_PC, outst=0, discard=0 and empties the address queue. All outputs are 0 during reset.
- States:
  - RST: unconditionally goes to FETCH on the first clock after reset deasserts; no request is issued in RST.
  - FETCH: normal issue.
  - DRAIN: discard>0; no issue. Goes to FETCH in the cycle after discard reaches 0.
- Credit: ok = (i_buf_cnt + outst) < BUF_DEPTH and outst < MAX_OUTST. Arithmetic is one bit wider than i_buf_cnt.
- o_req_vld = (state==FETCH) & ok & ~i_halt & ~i_redirect. This is combinational; o_req_addr = pc.
- Accept: o_req_vld & i_req_rdy.
  - pc <= pc+4; wraps modulo 2^XLEN.
  - The address is pushed into the address queue.
  - outst increments.
- Hold rule: while o_req_vld=1 and i_req_rdy=0, o_req_addr stays stable. The request may be withdrawn only by a redirect, halt or credit loss.
- Response while discard==0:
  - o_buf_wen=1 in the same cycle, o_buf_data={i_rsp_data, addr queue head}.
  - The address queue is popped.
  - outst decrements.
  - Zero latency, bus-to-buffer.
- Response while discard>0: dropped (o_buf_wen=0), discard and outst decrement, no pop.
- Accept and response in the same cycle: outst is unchanged; push and pop both occur.
- Redirect, i_redirect=1:
  - o_buf_flush=1 (combinational, same cycle). No issue, o_buf_wen=0.
  - pc <= i_redirect_pc & ~3.
  - The address queue is cleared.
  - discard <= outst - i_rsp_vld. A response arriving in the redirect cycle is dropped and counted.
  - outst <= outst - i_rsp_vld.
  - Next state: DRAIN if the new discard > 0, else FETCH.
- Redirect while in DRAIN: same formula; the new pc wins.
- Back-to-back redirects: the last pc wins.
- Credit after a flush: i_buf_cnt returns 0 one cycle after the flush; issue resumes no earlier than the cycle after the redirect.
- Overflow invariants (never permitted):
  - a response with outst==0;
  - a buffer write when i_buf_cnt==BUF_DEPTH.
  Both are asserted in simulation.
- i_halt only gates issue. Outstanding responses still drain into the buffer.

Decomposition:
- Shared package/defines:
  - RESET_PC;
  - state encodings (RST=2'd0, FETCH=2'd1, DRAIN=2'd2);
  - inst/addr width macros (xlen/ilen);
  - the buffer entry layout {inst[63:32], addr[31:0]}.
- Sub-module ifu_addr_queue: MAX_OUTST-deep, XLEN-wide register FIFO with push/pop/clear, head output and empty/full flags.
- The downstream instruction buffer is external.

Test Plan:
- Reset release, i_req_rdy=1, rsp 1 cycle later, buffer never drained → requests 0x80000000, …04, …08, …; issue stalls when i_buf_cnt+outst=8; buffer holds exactly 8 entries; never a 9th write.
- i_req_rdy held 0 for 5 cycles → o_req_addr stays 0x80000000, o_req_vld=1 throughout; pc advances only after accept.
- 3 requests outstanding, redirect to 0x80000103 → o_buf_flush pulse, discard=3, next request 0x80000100 only after the 3 stale responses, and none is written.
- Redirect in the same cycle as a response with outst=2 → that response is dropped, discard=1, one more drop, then FETCH.
- Two redirects on consecutive cycles (0x100 then 0x200) → first fetched address 0x200.
- i_halt=1 with 2 outstanding → no new requests, both responses written with correct addresses; deassert → issue resumes at the next pc.
